// File: rtl/pipe_mux_pkg.sv
// Shared limits and sizing helpers for the pipelined N:1 multiplexer.
package pipe_mux_pkg;

   localparam int MAX_N_IN  = 256;
   localparam int MIN_N_IN  = 2;
   localparam int MIN_GROUP = 2;

   // Ceiling log2; clog2(1) = 0. Inputs are bounded by MAX_N_IN.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Keeps a derived width usable as a vector width when it collapses to zero.
   function automatic int max1(input int value);
      return (value < 1) ? 1 : value;
   endfunction

endpackage

// File: rtl/mux_group.sv
// Combinational N:1 selector, DATA_W wide. A select with no matching slot
// (index >= N) yields zero.
module mux_group
   import pipe_mux_pkg::*;
#(
   parameter int DATA_W = 1,
   parameter int N      = 8,
   parameter int SEL_W  = max1(clog2(N))
) (
   input  logic [N*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]    in_sel,
   output logic [DATA_W-1:0]   out_data
);

   // Compare the select against every slot index; at most one can match.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(in_sel) == i) begin
            out_data = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/pipe_mux_n.sv
// Two-stage pipelined N_IN:1 multiplexer with valid/ready handshakes.
// Stage 1 picks one input per GROUP-sized bank with the low select bits;
// stage 2 picks among the bank results with the upper select bits.
// Out-of-range selects emerge as zero data with out_err set.
module pipe_mux_n
   import pipe_mux_pkg::*;
#(
   parameter  int DATA_W = 1,
   parameter  int N_IN   = 64,
   parameter  int GROUP  = 8,
   localparam int SEL_W  = clog2(N_IN)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_IN*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_err,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int LO_W   = clog2(GROUP);
   localparam int HI_W   = SEL_W - LO_W;      // zero when a single bank covers all inputs
   localparam int HI_W_R = max1(HI_W);
   localparam int N_GRP  = (N_IN + GROUP - 1) / GROUP;
   localparam int PAD_W  = N_GRP * GROUP * DATA_W;

   logic                    en1;
   logic                    en2;
   logic [PAD_W-1:0]        pad_data;
   logic [N_GRP*DATA_W-1:0] grp_data;
   logic [HI_W_R-1:0]       in_hi;
   logic                    in_err;
   logic [DATA_W-1:0]       sel2_data;

   logic                    s1_valid_q, s1_valid_d;
   logic [N_GRP*DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [HI_W_R-1:0]       s1_hi_q,    s1_hi_d;
   logic                    s1_err_q,   s1_err_d;

   logic                    out_valid_q, out_valid_d;
   logic [DATA_W-1:0]       out_data_q,  out_data_d;
   logic                    out_err_q,   out_err_d;

   // A stage may load when it is empty or its contents are leaving this cycle.
   assign en2      = ~out_valid_q | out_ready;
   assign en1      = ~s1_valid_q | en2;
   assign in_ready = en1;

   assign in_err = (32'(in_sel) >= 32'(N_IN));

   generate
      if (HI_W > 0) begin : g_hi
         assign in_hi = in_sel[SEL_W-1:LO_W];
      end else begin : g_no_hi
         assign in_hi = '0;
      end
   endgenerate

   // Zero-extend the input bus so unused slots in the last bank read as zero.
   always_comb begin
      pad_data                    = '0;
      pad_data[N_IN*DATA_W-1:0]   = in_data;
   end

   generate
      for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
         mux_group #(
            .DATA_W(DATA_W),
            .N     (GROUP),
            .SEL_W (LO_W)
         ) u_mux (
            .in_data (pad_data[gi*GROUP*DATA_W +: GROUP*DATA_W]),
            .in_sel  (in_sel[LO_W-1:0]),
            .out_data(grp_data[gi*DATA_W +: DATA_W])
         );
      end
   endgenerate

   mux_group #(
      .DATA_W(DATA_W),
      .N     (N_GRP),
      .SEL_W (HI_W_R)
   ) u_mux_final (
      .in_data (s1_data_q),
      .in_sel  (s1_hi_q),
      .out_data(sel2_data)
   );

   // Stage-1 next state: hold when stalled, capture bank results on an accepted input.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_hi_d    = s1_hi_q;
      s1_err_d   = s1_err_q;
      if (en1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = grp_data;
            s1_hi_d   = in_hi;
            s1_err_d  = in_err;
         end
      end
   end

   // Stage-1 valid bit, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
      end
   end

   // Stage-1 payload; only meaningful while s1_valid_q is set, so no reset.
   always_ff @(posedge clk) begin
      s1_data_q <= s1_data_d;
      s1_hi_q   <= s1_hi_d;
      s1_err_q  <= s1_err_d;
   end

   // Stage-2 next state: final selection, forcing zero data on an out-of-range select.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (en2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = s1_err_q ? '0 : sel2_data;
            out_err_d  = s1_err_q;
         end
      end
   end

   // Output register, fully cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Self-checking bench for pipe_mux_n: three configurations (8b x 64/8,
// 8b x 60/8, 1b x 2/2), each output checked against a queue-based model.
module tb_pipe_mux_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- DUT A: DATA_W=8, N_IN=64, GROUP=8 ----------------
   logic [511:0] in_data_a;
   logic [5:0]   in_sel_a;
   logic         in_valid_a, in_ready_a, out_err_a, out_valid_a, out_ready_a;
   logic [7:0]   out_data_a;

   pipe_mux_n #(.DATA_W(8), .N_IN(64), .GROUP(8)) u_dut_a (
      .clk(clk), .rst(rst), .in_data(in_data_a), .in_sel(in_sel_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
      .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(out_ready_a));

   // ---------------- DUT B: DATA_W=8, N_IN=60, GROUP=8 ----------------
   logic [479:0] in_data_b;
   logic [5:0]   in_sel_b;
   logic         in_valid_b, in_ready_b, out_err_b, out_valid_b, out_ready_b;
   logic [7:0]   out_data_b;

   pipe_mux_n #(.DATA_W(8), .N_IN(60), .GROUP(8)) u_dut_b (
      .clk(clk), .rst(rst), .in_data(in_data_b), .in_sel(in_sel_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
      .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(out_ready_b));

   // ---------------- DUT C: DATA_W=1, N_IN=2, GROUP=2 ----------------
   logic [1:0] in_data_c;
   logic [0:0] in_sel_c;
   logic       in_valid_c, in_ready_c, out_err_c, out_valid_c, out_ready_c;
   logic [0:0] out_data_c;

   pipe_mux_n #(.DATA_W(1), .N_IN(2), .GROUP(2)) u_dut_c (
      .clk(clk), .rst(rst), .in_data(in_data_c), .in_sel(in_sel_c),
      .in_valid(in_valid_c), .in_ready(in_ready_c), .out_data(out_data_c),
      .out_err(out_err_c), .out_valid(out_valid_c), .out_ready(out_ready_c));

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] d;
      logic       e;
      int         cyc;
   } item_t;

   item_t q_a[$];
   item_t q_b[$];
   int    ncyc  = 0;
   int    acc_a = 0;
   int    acc_b = 0;
   logic  exact_lat = 1'b0;

   function automatic logic [7:0] ref_a(input logic [511:0] d, input int sel);
      return d[sel*8 +: 8];
   endfunction

   function automatic logic [7:0] ref_b(input logic [479:0] d, input int sel);
      if (sel < 60) return d[sel*8 +: 8];
      return 8'h00;
   endfunction

   // An in-flight count of two means both stages are full; only then can a
   // stalled consumer block new input.
   logic       hold_a = 1'b0, hold_b = 1'b0;
   logic [7:0] hold_d_a, hold_d_b;
   logic       hold_e_a, hold_e_b;

   always @(negedge clk) begin
      item_t it;
      if (!rst) begin
         q_a.delete();
         q_b.delete();
         hold_a = 1'b0;
         hold_b = 1'b0;
      end else begin
         // ----- A -----
         if (hold_a) begin
            check("stall_valid_a", 64'(out_valid_a), 64'(1));
            check("stall_data_a", 64'(out_data_a), 64'(hold_d_a));
            check("stall_err_a", 64'(out_err_a), 64'(hold_e_a));
         end
         check("in_ready_a", 64'(in_ready_a), 64'((q_a.size() == 2 && !out_ready_a) ? 0 : 1));
         if (out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
               check("extra_out_a", 64'(out_valid_a), 64'(0));
            end else begin
               it = q_a.pop_front();
               check("data_a", 64'(out_data_a), 64'(it.d));
               check("err_a", 64'(out_err_a), 64'(it.e));
               if (exact_lat) check("lat_a", 64'(ncyc - it.cyc), 64'(2));
               else           check("lat_min_a", 64'((ncyc - it.cyc) >= 2), 64'(1));
            end
         end
         if (in_valid_a && in_ready_a) begin
            q_a.push_back('{d: ref_a(in_data_a, int'(in_sel_a)), e: 1'b0, cyc: ncyc});
            acc_a++;
         end
         hold_a   = out_valid_a && !out_ready_a;
         hold_d_a = out_data_a;
         hold_e_a = out_err_a;

         // ----- B -----
         if (hold_b) begin
            check("stall_valid_b", 64'(out_valid_b), 64'(1));
            check("stall_data_b", 64'(out_data_b), 64'(hold_d_b));
            check("stall_err_b", 64'(out_err_b), 64'(hold_e_b));
         end
         check("in_ready_b", 64'(in_ready_b), 64'((q_b.size() == 2 && !out_ready_b) ? 0 : 1));
         if (out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
               check("extra_out_b", 64'(out_valid_b), 64'(0));
            end else begin
               it = q_b.pop_front();
               check("data_b", 64'(out_data_b), 64'(it.d));
               check("err_b", 64'(out_err_b), 64'(it.e));
               check("lat_min_b", 64'((ncyc - it.cyc) >= 2), 64'(1));
            end
         end
         if (in_valid_b && in_ready_b) begin
            q_b.push_back('{d: ref_b(in_data_b, int'(in_sel_b)),
                            e: (int'(in_sel_b) >= 60), cyc: ncyc});
            acc_b++;
         end
         hold_b   = out_valid_b && !out_ready_b;
         hold_d_b = out_data_b;
         hold_e_b = out_err_b;
      end
      ncyc++;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] pat_c;
      int         target;
      int         guard;

      rst = 1'b0;
      in_data_a = '0; in_sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
      in_data_b = '0; in_sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      in_data_c = '0; in_sel_c = '0; in_valid_c = 1'b0; out_ready_c = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid_a", 64'(out_valid_a), 64'(0));
      check("rst_err_a", 64'(out_err_a), 64'(0));
      check("rst_data_a", 64'(out_data_a), 64'(0));
      check("rst_ready_a", 64'(in_ready_a), 64'(1));
      check("rst_valid_b", 64'(out_valid_b), 64'(0));
      check("rst_valid_c", 64'(out_valid_c), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // Sweep: input i carries i+1, every select once, consumer always ready.
      for (int i = 0; i < 64; i++) in_data_a[i*8 +: 8] = 8'(i + 1);
      out_ready_a = 1'b1;
      exact_lat   = 1'b1;
      for (int s = 0; s < 64; s++) begin
         in_valid_a = 1'b1;
         in_sel_a   = 6'(s);
         @(posedge clk); #1;
      end
      in_valid_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      exact_lat = 1'b0;
      check("sweep_count_a", 64'(acc_a), 64'(64));
      check("sweep_drain_a", 64'(q_a.size()), 64'(0));

      // Back-pressure: two items fill the pipe, the third must wait.
      out_ready_a = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid_a = 1'b1;
         in_sel_a   = 6'(10 + k);
         @(posedge clk); #1;
      end
      in_sel_a = 6'd12;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready_a", 64'(in_ready_a), 64'(0));
         check("bp_out_valid_a", 64'(out_valid_a), 64'(1));
      end
      check("bp_accepted_a", 64'(acc_a), 64'(66));
      @(posedge clk); #1;
      out_ready_a = 1'b1;
      @(posedge clk); #1;
      in_sel_a = 6'd13;
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("bp_accepted_all_a", 64'(acc_a), 64'(68));
      check("bp_drain_a", 64'(q_a.size()), 64'(0));

      // Reset with both stages full: everything in flight is discarded.
      out_ready_a = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid_a = 1'b1;
         in_sel_a   = 6'(20 + k);
         @(posedge clk); #1;
      end
      in_valid_a = 1'b0;
      @(negedge clk);
      check("full_before_rst_a", 64'(out_valid_a), 64'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_valid_a", 64'(out_valid_a), 64'(0));
      check("post_rst_ready_a", 64'(in_ready_a), 64'(1));
      out_ready_a = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_empty_a", 64'(q_a.size()), 64'(0));

      // Random traffic on A: 10k accepted items.
      target = acc_a + 10000;
      guard  = 0;
      while (acc_a < target && guard < 60000) begin
         in_valid_a  = 1'($urandom_range(0, 1));
         out_ready_a = 1'($urandom_range(0, 1));
         in_sel_a    = 6'($urandom_range(0, 63));
         for (int i = 0; i < 16; i++) in_data_a[i*32 +: 32] = $urandom;
         @(posedge clk); #1;
         guard++;
      end
      check("rand_count_a", 64'(acc_a >= target), 64'(1));
      in_valid_a  = 1'b0;
      out_ready_a = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_drain_a", 64'(q_a.size()), 64'(0));

      // B: out-of-range select then the last valid input.
      for (int i = 0; i < 60; i++) in_data_b[i*8 +: 8] = 8'(8'h80 + i);
      out_ready_b = 1'b1;
      in_valid_b  = 1'b1;
      in_sel_b    = 6'd61;
      @(posedge clk); #1;
      in_sel_b = 6'd59;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      @(negedge clk);
      check("oor_valid_b", 64'(out_valid_b), 64'(1));
      check("oor_data_b", 64'(out_data_b), 64'(8'h00));
      check("oor_err_b", 64'(out_err_b), 64'(1));
      @(negedge clk);
      check("last_valid_b", 64'(out_valid_b), 64'(1));
      check("last_data_b", 64'(out_data_b), 64'(8'h80 + 59));
      check("last_err_b", 64'(out_err_b), 64'(0));

      // Random traffic on B including out-of-range selects.
      target = acc_b + 2000;
      guard  = 0;
      while (acc_b < target && guard < 15000) begin
         in_valid_b  = 1'($urandom_range(0, 1));
         out_ready_b = 1'($urandom_range(0, 1));
         in_sel_b    = 6'($urandom_range(0, 63));
         for (int i = 0; i < 15; i++) in_data_b[i*32 +: 32] = $urandom;
         @(posedge clk); #1;
         guard++;
      end
      check("rand_count_b", 64'(acc_b >= target), 64'(1));
      in_valid_b  = 1'b0;
      out_ready_b = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_drain_b", 64'(q_b.size()), 64'(0));

      // C: two-input, one-bit mux, latency exactly two.
      out_ready_c = 1'b1;
      for (int p = 0; p < 2; p++) begin
         pat_c     = (p == 0) ? 2'b10 : 2'b01;
         in_data_c = pat_c;
         for (int s = 0; s < 2; s++) begin
            in_valid_c = 1'b1;
            in_sel_c   = 1'(s);
            @(posedge clk); #1;
            in_valid_c = 1'b0;
            @(negedge clk);
            check("early_valid_c", 64'(out_valid_c), 64'(0));
            @(posedge clk);
            @(negedge clk);
            check("valid_c", 64'(out_valid_c), 64'(1));
            check("data_c", 64'(out_data_c), 64'(pat_c[s]));
            check("err_c", 64'(out_err_c), 64'(0));
            @(posedge clk); #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
